// File: rtl/controle_excecao_pkg.sv
// -----------------------------------------------------------------------------
// controle_excecao_pkg
// Shared definitions for the exception sequencer of the multicycle MIPS
// datapath. The memory-address mux, the main control unit and the exception
// sequencer all import these selector codes, so the encodings stay consistent
// across the design.
//   - estado_t : sequencer states
//   - causa_t  : exception cause codes (also the value reported on 'causa')
//   - SEL_*    : memory-address mux selector codes
//   - VETOR_*  : handler-vector byte addresses reached by SEL_V253..SEL_V255
// -----------------------------------------------------------------------------
package controle_excecao_pkg;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    SALVA_EPC  = 2'd1,
    ESPERA     = 2'd2,
    CARREGA_PC = 2'd3
  } estado_t;

  typedef enum logic [1:0] {
    CAUSA_NENHUMA  = 2'b00,
    CAUSA_OPCODE   = 2'b01,
    CAUSA_OVERFLOW = 2'b10,
    CAUSA_DIVZERO  = 2'b11
  } causa_t;

  // Memory-address mux selector codes.
  localparam logic [3:0] SEL_PC     = 4'b0000;
  localparam logic [3:0] SEL_ULA    = 4'b0001;
  localparam logic [3:0] SEL_ALUOUT = 4'b0010;
  localparam logic [3:0] SEL_V253   = 4'b0011;
  localparam logic [3:0] SEL_V254   = 4'b0100;
  localparam logic [3:0] SEL_V255   = 4'b0101;

  // Handler-vector byte addresses selected by SEL_V253..SEL_V255.
  localparam logic [7:0] VETOR_OPCODE   = 8'd253;
  localparam logic [7:0] VETOR_OVERFLOW = 8'd254;
  localparam logic [7:0] VETOR_DIVZERO  = 8'd255;

  // Maps an exception cause to the mux selector that points at its vector.
  function automatic logic [3:0] sel_de_causa(input causa_t c);
    logic [3:0] sel;
    sel = SEL_PC;
    case (c)
      CAUSA_OPCODE:   sel = SEL_V253;
      CAUSA_OVERFLOW: sel = SEL_V254;
      CAUSA_DIVZERO:  sel = SEL_V255;
      default:        sel = SEL_PC;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/controle_excecao_if.sv
// -----------------------------------------------------------------------------
// controle_excecao_if
// Bundles the exception sequencer's datapath-facing signals.
//   Event pulses  : opcodeInexistente, overflow, divZero (one-cycle pulses)
//   Datapath in   : valorPC (current PC), dadoMemoria (memory read data)
//   Mux control   : seletorMuxMemoria, muxOverride
//   EPC write     : epcWrite, epcValor
//   PC write      : pcWrite, pcValor
//   Status        : ocupado (stall to control unit), causa (last cause)
// Modports:
//   slave  - the exception sequencer
//   master - the surrounding datapath / control unit
// -----------------------------------------------------------------------------
interface controle_excecao_if;
  logic        opcodeInexistente;
  logic        overflow;
  logic        divZero;
  logic [31:0] valorPC;
  logic [31:0] dadoMemoria;
  logic [3:0]  seletorMuxMemoria;
  logic        muxOverride;
  logic        epcWrite;
  logic [31:0] epcValor;
  logic        pcWrite;
  logic [31:0] pcValor;
  logic        ocupado;
  logic [1:0]  causa;

  modport slave (
    input  opcodeInexistente, overflow, divZero, valorPC, dadoMemoria,
    output seletorMuxMemoria, muxOverride, epcWrite, epcValor,
           pcWrite, pcValor, ocupado, causa
  );

  modport master (
    output opcodeInexistente, overflow, divZero, valorPC, dadoMemoria,
    input  seletorMuxMemoria, muxOverride, epcWrite, epcValor,
           pcWrite, pcValor, ocupado, causa
  );
endinterface

// File: rtl/controle_excecao.sv
// -----------------------------------------------------------------------------
// controle_excecao
// Exception sequencer for the multicycle MIPS datapath. On an invalid-opcode,
// overflow or divide-by-zero pulse it saves EPC, takes over the memory-address
// mux to read the handler-vector byte (253/254/255), waits for the memory read
// data and then loads PC with the zero-extended byte. The control unit is
// stalled (ocupado) for the whole MEM_WAIT+1 cycle sequence.
//
// Parameters:
//   MEM_WAIT   - cycles from address at the mux to valid dadoMemoria (1..15)
//   EPC_OFFSET - subtracted from valorPC to form EPC (PC already incremented)
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - controle_excecao_if.slave (pulses, PC/memory data, mux/EPC/PC
//           controls, stall and cause)
// -----------------------------------------------------------------------------
module controle_excecao
  import controle_excecao_pkg::*;
#(
  parameter int unsigned MEM_WAIT   = 1,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic             clk,
  input  logic             reset,
  controle_excecao_if.slave bus
);

  // The wait counter starts at MEM_WAIT-1 and the ESPERA state exits when it
  // reaches 1, giving exactly MEM_WAIT-1 ESPERA cycles.
  localparam logic [3:0] CNT_CARGA = 4'(MEM_WAIT - 1);

  estado_t     estado_q, estado_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  codigo_q, codigo_d;
  causa_t      causa_q, causa_d;
  logic [31:0] epc_valor_q, epc_valor_d;

  causa_t      causa_nova;
  logic        pedido;

  // Fixed priority: opcode > overflow > divZero; losers in the same cycle are
  // simply dropped.
  always_comb begin
    causa_nova = CAUSA_NENHUMA;
    if (bus.opcodeInexistente) begin
      causa_nova = CAUSA_OPCODE;
    end else if (bus.overflow) begin
      causa_nova = CAUSA_OVERFLOW;
    end else if (bus.divZero) begin
      causa_nova = CAUSA_DIVZERO;
    end
  end

  assign pedido = (causa_nova != CAUSA_NENHUMA);

  always_comb begin
    estado_d    = estado_q;
    cnt_d       = cnt_q;
    codigo_d    = codigo_q;
    causa_d     = causa_q;
    epc_valor_d = epc_valor_q;

    case (estado_q)
      OCIOSO: begin
        // Pulses are only sampled here; any other state ignores them.
        if (pedido) begin
          codigo_d    = sel_de_causa(causa_nova);
          causa_d     = causa_nova;
          // Registered so epcValor is valid throughout SALVA_EPC; the
          // subtraction wraps naturally at 32 bits.
          epc_valor_d = bus.valorPC - EPC_OFFSET;
          estado_d    = SALVA_EPC;
        end
      end

      SALVA_EPC: begin
        cnt_d    = CNT_CARGA;
        estado_d = (MEM_WAIT == 1) ? CARREGA_PC : ESPERA;
      end

      ESPERA: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          estado_d = CARREGA_PC;
        end
      end

      CARREGA_PC: begin
        estado_d = OCIOSO;
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      cnt_q       <= 4'd0;
      codigo_q    <= SEL_PC;
      causa_q     <= CAUSA_NENHUMA;
      epc_valor_q <= 32'd0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      codigo_q    <= codigo_d;
      causa_q     <= causa_d;
      epc_valor_q <= epc_valor_d;
    end
  end

  // State-decoded outputs. The selector only carries the latched code while
  // this block owns the mux; otherwise it reads SEL_PC.
  logic ativo;
  assign ativo = (estado_q != OCIOSO);

  assign bus.muxOverride       = ativo;
  assign bus.ocupado           = ativo;
  assign bus.seletorMuxMemoria = ativo ? codigo_q : SEL_PC;
  assign bus.epcWrite          = (estado_q == SALVA_EPC);
  assign bus.epcValor          = epc_valor_q;
  assign bus.pcWrite           = (estado_q == CARREGA_PC);
  assign bus.causa             = causa_q;

  // The handler address is a single byte fetched from the vector table.
  assign bus.pcValor           = {24'b0, bus.dadoMemoria[7:0]};

endmodule

// File: tb/tb_controle_excecao.sv
// -----------------------------------------------------------------------------
// tb_controle_excecao
// Drives two sequencer instances (MEM_WAIT = 1 and MEM_WAIT = 3) with the same
// inputs. A reference model tracks each instance as "position within the busy
// sequence" and predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_controle_excecao;
  import controle_excecao_pkg::*;

  logic clk;
  logic reset;
  logic t_op, t_ov, t_dz;
  logic [31:0] t_pc, t_dado;

  controle_excecao_if if1 ();
  controle_excecao_if if3 ();

  assign if1.opcodeInexistente = t_op;
  assign if1.overflow          = t_ov;
  assign if1.divZero           = t_dz;
  assign if1.valorPC           = t_pc;
  assign if1.dadoMemoria       = t_dado;
  assign if3.opcodeInexistente = t_op;
  assign if3.overflow          = t_ov;
  assign if3.divZero           = t_dz;
  assign if3.valorPC           = t_pc;
  assign if3.dadoMemoria       = t_dado;

  controle_excecao #(.MEM_WAIT(1), .EPC_OFFSET(32'd4)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );
  controle_excecao #(.MEM_WAIT(3), .EPC_OFFSET(32'd4)) dut3 (
    .clk(clk), .reset(reset), .bus(if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: pos = 0 idle, 1..MEM_WAIT+1 = cycle within the sequence.
  int          mw     [2] = '{1, 3};
  int          pos    [2];
  logic [3:0]  mcode  [2];
  logic [1:0]  mcausa [2];
  logic [31:0] mepc   [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic modelo_borda();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        pos[d] = 0; mcode[d] = 4'd0; mcausa[d] = 2'd0; mepc[d] = 32'd0;
      end else if (pos[d] == 0) begin
        if (t_op || t_ov || t_dz) begin
          pos[d]  = 1;
          mepc[d] = t_pc - 32'd4;
          if (t_op)      begin mcode[d] = 4'd3; mcausa[d] = 2'd1; end
          else if (t_ov) begin mcode[d] = 4'd4; mcausa[d] = 2'd2; end
          else           begin mcode[d] = 4'd5; mcausa[d] = 2'd3; end
        end
      end else if (pos[d] == mw[d] + 1) begin
        pos[d] = 0;
      end else begin
        pos[d] = pos[d] + 1;
      end
    end
  endtask

  task automatic confere(input int d, input string nome,
                         input logic [3:0] sel, input logic mo, input logic ew,
                         input logic [31:0] ev, input logic pw, input logic [31:0] pv,
                         input logic oc, input logic [1:0] ca);
    logic busy;
    busy = (pos[d] != 0);
    chk({nome, ".seletor"},  32'(sel), busy ? 32'(mcode[d]) : 32'd0);
    chk({nome, ".override"}, 32'(mo),  32'(busy));
    chk({nome, ".ocupado"},  32'(oc),  32'(busy));
    chk({nome, ".epcWrite"}, 32'(ew),  32'(pos[d] == 1));
    chk({nome, ".pcWrite"},  32'(pw),  32'(pos[d] == mw[d] + 1));
    chk({nome, ".epcValor"}, ev,       mepc[d]);
    chk({nome, ".pcValor"},  pv,       {24'b0, t_dado[7:0]});
    chk({nome, ".causa"},    32'(ca),  32'(mcausa[d]));
  endtask

  // One clock: apply inputs, advance the model at the edge, check on negedge.
  task automatic step(input logic op, input logic ov, input logic dz, input logic rs);
    t_op = op; t_ov = ov; t_dz = dz; reset = rs;
    @(posedge clk);
    modelo_borda();
    @(negedge clk);
    if (!$isunknown(pos[0])) begin
      confere(0, "mw1", if1.seletorMuxMemoria, if1.muxOverride, if1.epcWrite, if1.epcValor,
              if1.pcWrite, if1.pcValor, if1.ocupado, if1.causa);
      confere(1, "mw3", if3.seletorMuxMemoria, if3.muxOverride, if3.epcWrite, if3.epcValor,
              if3.pcWrite, if3.pcValor, if3.ocupado, if3.causa);
    end
  endtask

  task automatic ocioso(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    t_op = 0; t_ov = 0; t_dz = 0; reset = 1;
    t_pc = 32'h0000_0010; t_dado = 32'h0000_0040;
    for (int d = 0; d < 2; d++) begin
      pos[d] = 0; mcode[d] = 0; mcausa[d] = 0; mepc[d] = 0;
    end
    @(negedge clk);

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset.ocupado", 32'(if1.ocupado), 32'd0);
    chk("reset.causa",   32'(if3.causa),   32'd0);
    ocioso(2);

    // Overflow with MEM_WAIT = 1: T+1 EPC save, T+2 PC load, T+3 idle
    step(0, 1, 0, 0);
    chk("ov.epcWrite", 32'(if1.epcWrite), 32'd1);
    chk("ov.epcValor", if1.epcValor, 32'h0000_000C);
    chk("ov.seletor",  32'(if1.seletorMuxMemoria), 32'(SEL_V254));
    chk("ov.override", 32'(if1.muxOverride), 32'd1);
    step(0, 0, 0, 0);
    chk("ov.pcWrite", 32'(if1.pcWrite), 32'd1);
    chk("ov.pcValor", if1.pcValor, 32'h0000_0040);
    step(0, 0, 0, 0);
    chk("ov.ocupado", 32'(if1.ocupado), 32'd0);
    chk("ov.causa",   32'(if1.causa),   32'b10);
    ocioso(3);

    // Opcode and divZero together: opcode wins, single sequence
    step(1, 0, 1, 0);
    chk("prio.seletor", 32'(if1.seletorMuxMemoria), 32'(SEL_V253));
    chk("prio.causa",   32'(if1.causa), 32'b01);
    ocioso(6);
    chk("prio.idle", 32'(if3.ocupado), 32'd0);

    // MEM_WAIT = 3 divZero: selector held 4 cycles, pcWrite on the 4th
    t_dado = 32'hABCD_12FF;
    step(0, 0, 1, 0);
    chk("mw3.sel1", 32'(if3.seletorMuxMemoria), 32'(SEL_V255));
    chk("mw3.pw1",  32'(if3.pcWrite), 32'd0);
    step(0, 0, 0, 0);
    chk("mw3.sel2", 32'(if3.seletorMuxMemoria), 32'(SEL_V255));
    step(0, 0, 0, 0);
    chk("mw3.pw3",  32'(if3.pcWrite), 32'd0);
    step(0, 0, 0, 0);
    chk("mw3.pw4",  32'(if3.pcWrite), 32'd1);
    chk("mw3.pcValor", if3.pcValor, 32'h0000_00FF);
    step(0, 0, 0, 0);
    chk("mw3.fim", 32'(if3.muxOverride), 32'd0);
    ocioso(2);

    // Overflow during ESPERA ignored; pulse on return to idle accepted
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("ign.causa", 32'(if3.causa), 32'b11);
    step(0, 0, 0, 0);
    chk("ign.pcWrite", 32'(if3.pcWrite), 32'd1);
    step(0, 1, 0, 0);
    chk("ign.idle", 32'(if3.ocupado), 32'd0);
    step(0, 1, 0, 0);
    chk("novo.causa",    32'(if3.causa),    32'b10);
    chk("novo.epcWrite", 32'(if3.epcWrite), 32'd1);
    ocioso(6);

    // Reset in ESPERA aborts the sequence
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("rst.ocupado", 32'(if3.ocupado), 32'd0);
    chk("rst.seletor", 32'(if3.seletorMuxMemoria), 32'd0);
    chk("rst.causa",   32'(if3.causa), 32'd0);
    chk("rst.epc",     if3.epcValor, 32'd0);
    ocioso(5);

    // EPC wrap-around
    t_pc = 32'h0000_0000;
    step(0, 1, 0, 0);
    chk("wrap.epcValor", if1.epcValor, 32'hFFFF_FFFC);
    ocioso(6);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      t_pc   = $urandom;
      t_dado = $urandom;
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
